// File: rtl/he_lb_axi_mem_rsp_pkg.sv
// ---------------------------------------------------------------------------
// he_lb_axi_mem_rsp_pkg
// Shared types and constants for the HE LB AXI4 memory responder:
//   wr_state_t  - write-channel FSM states (address, data, response)
//   rd_state_t  - read-channel FSM states (idle, streaming data)
//   RESP_OKAY / RESP_SLVERR - AXI response encodings used on bresp/rresp
// ---------------------------------------------------------------------------
package he_lb_axi_mem_rsp_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/he_lb_axi_mem_rsp_ram.sv
// ---------------------------------------------------------------------------
// he_lb_axi_mem_rsp_ram
// DEPTH x DATA_WIDTH storage behind the AXI memory responder.
//   clk, rst_n            - clock, async active-low reset (read register only)
//   we_i/waddr_i/wdata_i/wstrb_i - byte-enable write port
//   re_i/raddr_i          - read enable and word index
//   rdata_o               - registered read data, holds while re_i is low
// A write and a read of the same word in one cycle returns the old contents.
// ---------------------------------------------------------------------------
module he_lb_axi_mem_rsp_ram
    import he_lb_axi_mem_rsp_pkg::*;
#(
    parameter  int DATA_WIDTH = 512,
    parameter  int DEPTH      = 16,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic                  re_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage array is intentionally left unreset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Output register only updates on re_i so a stalled reader sees stable data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/he_lb_axi_mem_rsp.sv
// ---------------------------------------------------------------------------
// he_lb_axi_mem_rsp
// AXI4 slave backed by a small on-chip RAM; terminates HE LB's external
// memory port with real B/R responses. INCR bursts only, one outstanding
// transaction per direction, read and write channels fully independent.
// Ports:
//   clk, rst_n                         - clock, async active-low reset
//   aw*_i / awready_o                  - write address (id, byte addr, len)
//   w*_i  / wready_o                   - write data, strobes, last
//   bvalid_o/bid_o/bresp_o, bready_i   - write response (SLVERR on wlast misuse)
//   ar*_i / arready_o                  - read address (id, byte addr, len)
//   rvalid_o/rid_o/rdata_o/rresp_o/rlast_o, rready_i - read data
// ---------------------------------------------------------------------------
module he_lb_axi_mem_rsp
    import he_lb_axi_mem_rsp_pkg::*;
#(
    parameter  int ADDR_WIDTH = 10,
    parameter  int DATA_WIDTH = 512,
    parameter  int ID_WIDTH   = 4,
    parameter  int DEPTH      = 16,
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ID_WIDTH-1:0]   awid_i,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [7:0]            awlen_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic                  wlast_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [ID_WIDTH-1:0]   bid_o,
    output logic [1:0]            bresp_o,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ID_WIDTH-1:0]   arid_i,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [7:0]            arlen_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [ID_WIDTH-1:0]   rid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o
);

    // Byte offset bits are dropped; the index field's width gives the mod-DEPTH wrap.
    localparam int OFFS  = $clog2(STRB_W);
    localparam int IDX_W = $clog2(DEPTH);

    wr_state_t             wr_state_q, wr_state_d;
    logic [ID_WIDTH-1:0]   wr_id_q;
    logic [IDX_W-1:0]      wr_idx_q;
    logic [7:0]            wr_cnt_q;
    logic                  wr_err_q;

    rd_state_t             rd_state_q, rd_state_d;
    logic [ID_WIDTH-1:0]   rd_id_q;
    logic [IDX_W-1:0]      rd_idx_q;
    logic [7:0]            rd_cnt_q;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  beat_err;
    logic                  ram_re;
    logic [IDX_W-1:0]      ram_raddr;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{awaddr_i, araddr_i};

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign b_hs  = bvalid_o && bready_i;
    assign ar_hs = arvalid_i && arready_o;
    assign r_hs  = rvalid_o && rready_i;

    // wlast must coincide exactly with the final counted beat.
    assign beat_err = wlast_i ? (wr_cnt_q != 8'd0) : (wr_cnt_q == 8'd0);

    // ---------------- write channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    // The burst is closed by the counter, not by wlast.
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
            W_DATA:  if (w_hs && wr_cnt_q == 8'd0) wr_state_d = W_RESP;
            W_RESP:  if (b_hs) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready_o = (wr_state_q == W_IDLE);
        wready_o  = (wr_state_q == W_DATA);
        bvalid_o  = (wr_state_q == W_RESP);
        bid_o     = wr_id_q;
        bresp_o   = (bvalid_o && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_id_q  <= '0;
            wr_idx_q <= '0;
            wr_cnt_q <= '0;
            wr_err_q <= 1'b0;
        end else if (aw_hs) begin
            wr_id_q  <= awid_i;
            wr_idx_q <= awaddr_i[OFFS +: IDX_W];
            wr_cnt_q <= awlen_i;
            wr_err_q <= 1'b0;
        end else if (w_hs) begin
            wr_idx_q <= wr_idx_q + IDX_W'(1);
            wr_cnt_q <= wr_cnt_q - 8'd1;
            wr_err_q <= wr_err_q | beat_err;
        end else if (b_hs) begin
            wr_err_q <= 1'b0;
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
        end else begin
            rd_state_q <= rd_state_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (r_hs && rd_cnt_q == 8'd0) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_o = (rd_state_q == R_IDLE);
        rvalid_o  = (rd_state_q == R_DATA);
        rlast_o   = rvalid_o && (rd_cnt_q == 8'd0);
        rid_o     = rd_id_q;
        rresp_o   = RESP_OKAY;
    end

    // The RAM is read on the ar handshake and on every accepted non-final beat,
    // so the next word is already registered when the following beat is presented.
    always_comb begin
        ram_re    = ar_hs || (r_hs && rd_cnt_q != 8'd0);
        ram_raddr = ar_hs ? araddr_i[OFFS +: IDX_W] : rd_idx_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_id_q  <= '0;
            rd_idx_q <= '0;
            rd_cnt_q <= '0;
        end else if (ar_hs) begin
            rd_id_q  <= arid_i;
            rd_idx_q <= araddr_i[OFFS +: IDX_W];
            rd_cnt_q <= arlen_i;
        end else if (r_hs && rd_cnt_q != 8'd0) begin
            rd_idx_q <= rd_idx_q + IDX_W'(1);
            rd_cnt_q <= rd_cnt_q - 8'd1;
        end
    end

    he_lb_axi_mem_rsp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_hs),
        .waddr_i (wr_idx_q),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (rdata_o)
    );

endmodule

// File: doc/he_lb_axi_mem_rsp.md
Name: he_lb_axi_mem_rsp

Overview:
AXI4 memory responder that serves as the far end of HE LB's external-memory AXI port. It is backed by a small on-chip RAM and replaces the static ready/valid tie-off in PCIe-only HE LB builds. Traffic from he_lb_main's memory path therefore completes with real B and R responses and real data. It sits beside he_lb_main at the top level, on the same clock as the host logic.

Parameters:
ADDR_WIDTH, 10, byte-address width of aw/araddr
DATA_WIDTH, 512, data bus width in bits; must be a power of 2, >= 32
ID_WIDTH, 4, width of awid/bid/arid/rid
DEPTH, 16, RAM depth in DATA_WIDTH words; power of 2; DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awvalid/awready  in/out  1/1  write-address handshake
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  write start byte address
awlen  in  8  write beats minus 1
wvalid/wready  in/out  1/1  write-data handshake
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte enables
wlast  in  1  last write beat
bvalid/bready  out/in  1/1  write-response handshake
bid  out  ID_WIDTH  echoed awid
bresp  out  2  write response
arvalid/arready  in/out  1/1  read-address handshake
arid  in  ID_WIDTH  read ID
araddr  in  ADDR_WIDTH  read start byte address
arlen  in  8  read beats minus 1
rvalid/rready  out/in  1/1  read-data handshake
rid  out  ID_WIDTH  echoed arid
rdata  out  DATA_WIDTH  read data
rresp  out  2  always 2'b00
rlast  out  1  last read beat

Behaviour:
- Reset (async assert, sync deassert to clk): awready=arready=1, wready=bvalid=rvalid=rlast=0, bresp=0, bid=rid=0, rdata=0. RAM contents are not reset. Reset mid-burst abandons the burst; no response is issued.
- Word index = (addr >> log2(DATA_WIDTH/8)) mod DEPTH. Address low bits are ignored. Bursts are INCR only; awburst/arsize are not ported. The index wraps modulo DEPTH within a burst.
- Write FSM:
  - W_IDLE: awready=1. On awvalid, latch id, index, and count=awlen, then go to W_DATA.
  - W_DATA: wready=1. Each w handshake writes the bytes of RAM[index] whose wstrb bit is 1, increments index, and decrements count.
  - Error check on each beat: flag an error if wlast=1 while count!=0, or wlast=0 while count==0.
  - The beat with count==0 ends the burst and goes to W_RESP; any extra beats are not accepted.
- W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if the error flag is set, else 2'b00. On bready, go to W_IDLE and clear the flag. The earliest next awready is the cycle after the b handshake.
- Read FSM:
  - R_IDLE: arready=1. On arvalid, latch id, index, and count=arlen, then go to R_DATA.
  - R_DATA: rdata is registered. The first rvalid appears exactly 1 cycle after the ar handshake.
  - rlast = (count==0).
  - On each r handshake with count!=0, load RAM[index+1] into rdata and keep rvalid=1, giving 1 beat/cycle.
  - On the handshake with count==0, drop rvalid and go to R_IDLE; arready rises the next cycle.
  - While rready=0, rvalid, rdata, rid and rlast hold stable.
- Read and write FSMs are independent and may run concurrently. For a same-cycle read load and write to the same word, the read returns the old data (read-before-write).
- aw and ar handshakes in the same cycle are both accepted.
- Input IDs are not reordered; one outstanding transaction per direction.

Decomposition:
- Package he_lb_axi_mem_rsp_pkg:
  - wr_state_t {W_IDLE, W_DATA, W_RESP}
  - rd_state_t {R_IDLE, R_DATA}
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
- One sub-module he_lb_axi_mem_rsp_ram: DEPTH x DATA_WIDTH, byte-enable write port, registered read port with a read-enable.

Test Plan:
- Single write, addr 0x040, awlen 0, wdata=A5.., wstrb all 1 -> wready 1 cycle, then bvalid with bresp 00 and bid echoed. Read of 0x040, arlen 0 -> rvalid 1 cycle after ar, rdata=A5.., rlast=1, rid echoed.
- 4-beat write from word 14 (DEPTH 16) -> words 14,15,0,1 written (index wrap). 4-beat read with rready held 1 -> 4 consecutive rvalid beats, rlast only on beat 4.
- Partial strobe: write all-FF, then write 00 with wstrb=...0001 -> read returns byte0=00, remaining bytes FF.
- wlast asserted on beat 2 of an awlen=3 burst -> all 4 beats accepted, then bresp=2'b10.
- rready toggled 1/0 during an 8-beat read -> no beat lost or duplicated; outputs stable while stalled. A concurrent same-word write returns old data on the overlapping beat.
- rst_n asserted mid read burst -> rvalid=0 and arready=1 immediately (async). A new read after reset completes normally.
